// File: rtl/ksa_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder.
package ksa_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/ksa_prefix_cell.sv
// One registered Kogge-Stone prefix node: black cell (Black=1) or plain delay (Black=0).
module ksa_prefix_cell
  import ksa_pkg::*;
#(
  parameter bit Black = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stall_i,
  input  pg_t  cur_i,
  input  pg_t  prev_i,
  output pg_t  pg_o
);

  pg_t black, pg_d, pg_q;

  always_comb begin
    black.g = cur_i.g | (cur_i.p & prev_i.g);
    black.p = cur_i.p & prev_i.p;
    pg_d    = pg_q;
    if (!stall_i) pg_d = Black ? black : cur_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pg_q <= '0;
    else       pg_q <= pg_d;
  end

  assign pg_o = pg_q;

endmodule

// File: rtl/ksa_pipe.sv
// Fully pipelined Kogge-Stone add/subtract, latency log2(WIDTH)+2, global stall.
// Optional overflow output enabled by defining KSA_PIPE_OVF_EN.
module ksa_pipe
  import ksa_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             GCLK_Pad,
  input  logic             RST_Pad,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef KSA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned STAGES = clog2(WIDTH);
  localparam int unsigned LAT    = STAGES + 2;
  localparam int unsigned DEPTH  = LAT - 1;

  if ((WIDTH < 2) || (WIDTH > MAX_WIDTH) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("ksa_pipe: WIDTH must be a power of two between 2 and 64");
  end

  logic [WIDTH-1:0] b_eff;
  logic             c0_in;
  pg_t              pg0_d [WIDTH];
  pg_t              pg0_q [WIDTH];
  pg_t              lvl   [STAGES+1][WIDTH];

  // Side pipelines keep p, c0 and valid aligned with the prefix levels.
  logic [WIDTH-1:0] p_d   [DEPTH];
  logic [WIDTH-1:0] p_q   [DEPTH];
  logic             c0_d  [DEPTH];
  logic             c0_q  [DEPTH];
  logic             vld_d [DEPTH];
  logic             vld_q [DEPTH];

  logic [WIDTH-1:0] g_fin, p_fin, sum_new, sum_d, sum_q;
  logic             cout_d, cout_q, out_valid_d, out_valid_q;
  logic             unused_p_fin;

  always_comb begin
    b_eff = sub ? ~b : b;
    c0_in = sub ? ~cin : cin;
    for (int i = 0; i < WIDTH; i++) begin
      pg0_d[i] = pg0_q[i];
      if (!stall) begin
        pg0_d[i].g = a[i] & b_eff[i];
        pg0_d[i].p = a[i] ^ b_eff[i];
      end
    end
    // Bit 0 absorbs the carry-in so every group generate already includes c0.
    if (!stall) pg0_d[0].g = (a[0] & b_eff[0]) | ((a[0] ^ b_eff[0]) & c0_in);

    p_d[0]   = stall ? p_q[0]   : (a ^ b_eff);
    c0_d[0]  = stall ? c0_q[0]  : c0_in;
    vld_d[0] = stall ? vld_q[0] : in_valid;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      p_d[k]   = stall ? p_q[k]   : p_q[k-1];
      c0_d[k]  = stall ? c0_q[k]  : c0_q[k-1];
      vld_d[k] = stall ? vld_q[k] : vld_q[k-1];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lvl0
    assign lvl[0][i] = pg0_q[i];
  end

  for (genvar k = 1; k <= STAGES; k++) begin : g_level
    localparam int Span = 1 << (k - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= Span) begin : g_black
        ksa_prefix_cell #(.Black(1'b1)) u_cell (
          .clk_i  (GCLK_Pad),
          .rst_i  (RST_Pad),
          .stall_i(stall),
          .cur_i  (lvl[k-1][i]),
          .prev_i (lvl[k-1][i-Span]),
          .pg_o   (lvl[k][i])
        );
      end else begin : g_pass
        ksa_prefix_cell #(.Black(1'b0)) u_cell (
          .clk_i  (GCLK_Pad),
          .rst_i  (RST_Pad),
          .stall_i(stall),
          .cur_i  (lvl[k-1][i]),
          .prev_i (lvl[k-1][i]),
          .pg_o   (lvl[k][i])
        );
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      g_fin[i] = lvl[STAGES][i].g;
      p_fin[i] = lvl[STAGES][i].p;
    end
    sum_new     = p_q[STAGES] ^ {g_fin[WIDTH-2:0], c0_q[STAGES]};
    sum_d       = stall ? sum_q : sum_new;
    cout_d      = stall ? cout_q : g_fin[WIDTH-1];
    out_valid_d = stall ? out_valid_q : vld_q[STAGES];
  end

  assign unused_p_fin = ^p_fin;

  always_ff @(posedge GCLK_Pad or posedge RST_Pad) begin
    if (RST_Pad) begin
      for (int i = 0; i < WIDTH; i++) pg0_q[i] <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        p_q[k]   <= '0;
        c0_q[k]  <= 1'b0;
        vld_q[k] <= 1'b0;
      end
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      pg0_q       <= pg0_d;
      p_q         <= p_d;
      c0_q        <= c0_d;
      vld_q       <= vld_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

`ifdef KSA_PIPE_OVF_EN
  logic am_d [DEPTH];
  logic am_q [DEPTH];
  logic bm_d [DEPTH];
  logic bm_q [DEPTH];
  logic ovf_d, ovf_q;

  always_comb begin
    am_d[0] = stall ? am_q[0] : a[WIDTH-1];
    bm_d[0] = stall ? bm_q[0] : b_eff[WIDTH-1];
    for (int unsigned k = 1; k < DEPTH; k++) begin
      am_d[k] = stall ? am_q[k] : am_q[k-1];
      bm_d[k] = stall ? bm_q[k] : bm_q[k-1];
    end
    ovf_d = stall ? ovf_q
                  : ((am_q[STAGES] == bm_q[STAGES]) && (sum_new[WIDTH-1] != am_q[STAGES]));
  end

  always_ff @(posedge GCLK_Pad or posedge RST_Pad) begin
    if (RST_Pad) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        am_q[k] <= 1'b0;
        bm_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      am_q  <= am_d;
      bm_q  <= bm_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ksa_pipe.sv
// Directed and random checks of ksa_pipe at WIDTH=8 (LAT=5).
module tb_ksa_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       stall = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       out_valid;
  logic [7:0] sum;
  logic       cout;
`ifdef KSA_PIPE_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  ksa_pipe #(.WIDTH(8)) dut (
    .GCLK_Pad (clk),
    .RST_Pad  (rst),
    .in_valid (in_valid),
    .stall    (stall),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .sum      (sum),
    .cout     (cout)
`ifdef KSA_PIPE_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic mc, input logic ms);
    logic [7:0] bq;
    logic       c;
    logic [8:0] r;
    bq = ms ? ~mb : mb;
    c  = ms ? ~mc : mc;
    r  = {1'b0, ma} + {1'b0, bq} + {8'd0, c};
    return {(ma[7] == bq[7]) && (r[7] != ma[7]), r};
  endfunction

  // Drive one cycle of inputs just after the rising edge, return at the falling edge.
  task automatic issue(input logic v, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc, input logic ts, input logic tst);
    @(posedge clk);
    #1;
    in_valid = v;
    a = ta;
    b = tb_;
    cin = tc;
    sub = ts;
    stall = tst;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, cout, sum} !== 10'd0)
      $display("FAIL reset_async: got %b expected 0", {out_valid, cout, sum});
    else n_pass++;
    for (int j = 0; j < 3; j++) begin
      issue(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({out_valid, cout, sum} !== 10'd0)
        $display("FAIL reset_hold[%0d]: got %b expected 0", j, {out_valid, cout, sum});
      else n_pass++;
    end
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    for (int j = 0; j < 10; j++) begin
      issue(j == 0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (j == 5) begin
        if ({out_valid, cout, sum} !== {1'b1, 1'b1, 8'h00})
          $display("FAIL wrap_result: got v=%b c=%b s=%h expected v=1 c=1 s=00",
                   out_valid, cout, sum);
        else n_pass++;
      end else begin
        if (out_valid !== 1'b0)
          $display("FAIL wrap_idle[%0d]: got out_valid=%b expected 0", j, out_valid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sub();
    for (int j = 0; j < 10; j++) begin
      issue(j < 2, (j == 0) ? 8'h05 : 8'h07, (j == 0) ? 8'h07 : 8'h05, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (j == 5) begin
        if ({out_valid, cout, sum} !== {1'b1, 1'b0, 8'hFE})
          $display("FAIL sub_5m7: got v=%b c=%b s=%h expected v=1 c=0 s=fe", out_valid, cout, sum);
        else n_pass++;
      end else if (j == 6) begin
        if ({out_valid, cout, sum} !== {1'b1, 1'b1, 8'h02})
          $display("FAIL sub_7m5: got v=%b c=%b s=%h expected v=1 c=1 s=02", out_valid, cout, sum);
        else n_pass++;
      end else begin
        if (out_valid !== 1'b0)
          $display("FAIL sub_idle[%0d]: got out_valid=%b expected 0", j, out_valid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_r [500];
    logic [9:0] m;
    logic [7:0] ra, rb;
    logic       rc, rs;
    for (int t = 0; t < 505; t++) begin
      if (t < 500) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        m  = model(ra, rb, rc, rs);
        exp_r[t] = m[8:0];
        issue(1'b1, ra, rb, rc, rs, 1'b0);
      end else begin
        issue(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      end
      n_checks++;
      if (t >= 5) begin
        if ({out_valid, cout, sum} !== {1'b1, exp_r[t-5]})
          $display("FAIL b2b[%0d]: got v=%b c=%b s=%h expected v=1 c=%b s=%h",
                   t - 5, out_valid, cout, sum, exp_r[t-5][8], exp_r[t-5][7:0]);
        else n_pass++;
      end else begin
        if (out_valid !== 1'b0)
          $display("FAIL b2b_fill[%0d]: got out_valid=%b expected 0", t, out_valid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] oa [4] = '{8'h11, 8'hF0, 8'h30, 8'h80};
    logic [7:0] ob [4] = '{8'h22, 8'h20, 8'h40, 8'h80};
    logic       oc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       os [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [8:0] ex [4] = '{9'h033, 9'h111, 9'h0F0, 9'h101};
    for (int t = 0; t < 17; t++) begin
      if (t < 4)      issue(1'b1, oa[t], ob[t], oc[t], os[t], 1'b0);
      else if (t < 7) issue(1'b1, 8'hAA, 8'h55, 1'b1, 1'b0, 1'b1);
      else            issue(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (t >= 8 && t < 12) begin
        if ({out_valid, cout, sum} !== {1'b1, ex[t-8]})
          $display("FAIL stall_res[%0d]: got v=%b c=%b s=%h expected v=1 c=%b s=%h",
                   t - 8, out_valid, cout, sum, ex[t-8][8], ex[t-8][7:0]);
        else n_pass++;
      end else begin
        if (out_valid !== 1'b0)
          $display("FAIL stall_idle[%0d]: got out_valid=%b expected 0", t, out_valid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t < 7; t++) issue(1'b1, 8'h40 + 8'(t), 8'h01, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({out_valid, cout, sum} !== {1'b1, 1'b0, 8'h42})
      $display("FAIL rstmid_pre: got v=%b c=%b s=%h expected v=1 c=0 s=42", out_valid, cout, sum);
    else n_pass++;
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, cout, sum} !== 10'd0)
      $display("FAIL rstmid_async: got %b expected 0", {out_valid, cout, sum});
    else n_pass++;
    #1 rst = 1'b0;
    for (int j = 0; j < 11; j++) begin
      issue(j == 3, 8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (j == 8) begin
        if ({out_valid, cout, sum} !== {1'b1, 1'b0, 8'h47})
          $display("FAIL rstmid_fresh: got v=%b c=%b s=%h expected v=1 c=0 s=47",
                   out_valid, cout, sum);
        else n_pass++;
      end else begin
        if (out_valid !== 1'b0)
          $display("FAIL rstmid_stale[%0d]: got out_valid=%b expected 0", j, out_valid);
        else n_pass++;
      end
    end
  endtask

`ifdef KSA_PIPE_OVF_EN
  task automatic test_ovf();
    logic [7:0] oa [3] = '{8'h7F, 8'h80, 8'h10};
    logic [7:0] ob [3] = '{8'h01, 8'h01, 8'h20};
    logic       os [3] = '{1'b0, 1'b1, 1'b0};
    logic [8:0] ex [3] = '{9'h180, 9'h17F, 9'h030};
    for (int j = 0; j < 10; j++) begin
      if (j < 3) issue(1'b1, oa[j], ob[j], 1'b0, os[j], 1'b0);
      else       issue(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      if (j >= 5 && j < 8) begin
        n_checks++;
        if ({out_valid, ovf, sum} !== {1'b1, ex[j-5]})
          $display("FAIL ovf[%0d]: got v=%b ovf=%b s=%h expected v=1 ovf=%b s=%h",
                   j - 5, out_valid, ovf, sum, ex[j-5][8], ex[j-5][7:0]);
        else n_pass++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_sub();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef KSA_PIPE_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ksa_pipe.md
KSA_PIPE -- requirements
Module: ksa_pipe

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width; legal values are powers of two from 2 to 64, and any other value SHALL stop elaboration with an error.
REQ-002 Derived constant STAGES = log2(WIDTH) SHALL give the number of prefix levels; LAT = STAGES+2 SHALL give the latency in cycles.
REQ-003 GCLK_Pad  input  1  global clock; all state updates on the rising edge.
REQ-004 RST_Pad  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  marks a, b, cin and sub as a valid operation this cycle.
REQ-006 stall  input  1  freezes every pipeline stage while high.
REQ-007 sub  input  1  0 = add, 1 = subtract.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in when adding; borrow-in when subtracting.
REQ-011 out_valid  output  1  marks sum and cout as a result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry-out from the MSB.

Function
REQ-014 Stage 0 SHALL register the per-bit values g = a & b', p = a ^ b' and c0, where b' = sub ? ~b : b and c0 = sub ? ~cin : cin.
REQ-015 Stages 1..STAGES SHALL each register one Kogge-Stone prefix level at span 2^(k-1): black cell for bit i >= span, pass-through for bit i < span.
REQ-016 Every signal that skips a logic level (p, c0, pass-through bits) SHALL be delayed by a register so that all paths have equal depth, with no combinational bypass.
REQ-017 The final stage SHALL register sum = p ^ {G[WIDTH-2:0],c0} and cout = G[WIDTH-1], where G includes c0 as the group generate.
REQ-018 The block SHALL be fully pipelined: with stall low, one operation is accepted every cycle and its result appears exactly LAT cycles later.
REQ-019 Results SHALL appear in issue order, with no reordering or dropping.
REQ-020 A valid bit SHALL travel alongside the data through every stage; out_valid is that bit at the last stage.
REQ-021 Data registers SHALL load every non-stalled cycle whatever the valid bit; sum and cout are meaningful only while out_valid=1.
REQ-022 While stall=1, all registers, including the valid bits and the outputs, SHALL hold; in_valid during a stalled cycle is ignored and the operation is lost.
REQ-023 Stall lasting any number of cycles SHALL add exactly that many cycles to the latency of in-flight operations and SHALL NOT corrupt them.
REQ-024 Width arithmetic SHALL be modulo 2^WIDTH; 8'hFF+8'h01 wraps to 8'h00 with cout=1.

Reset
REQ-025 Asserting RST_Pad SHALL immediately clear all valid bits, out_valid, sum and cout to 0, independent of the clock.
REQ-026 Operations in flight at reset SHALL be discarded and never reported.
REQ-027 After deassertion, the first valid operation SHALL produce out_valid exactly LAT cycles later.

Configuration
REQ-028 Macro KSA_PIPE_OVF_EN defined: an extra output ovf (output, 1 bit) SHALL report two's-complement overflow, aligned with sum and reset to 0.
REQ-029 ovf SHALL equal (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), with a[MSB] and b'[MSB] carried through the pipeline.
REQ-030 Macro not defined: port ovf and its pipeline registers SHALL NOT exist, and all other behaviour is unchanged.

Structure
REQ-031 Package ksa_pkg SHALL hold the pg_t struct {g, p}, a clog2 constant function and the MAX_WIDTH=64 constant.
REQ-032 One sub-module, ksa_prefix_cell, SHALL implement a registered black cell or delay cell (selected by a parameter) with stall and asynchronous reset; ksa_pipe instantiates it per bit per level.

Verification (WIDTH=8, LAT=5)
REQ-033 a=8'hFF, b=8'h01, cin=0, sub=0, one cycle -> after 5 cycles out_valid=1, sum=8'h00, cout=1, and out_valid=0 on all other cycles.
REQ-034 a=8'h05, b=8'h07, cin=0, sub=1 -> sum=8'hFE, cout=0; a=8'h07, b=8'h05, sub=1 -> sum=8'h02, cout=1.
REQ-035 500 random back-to-back operations with random sub and cin -> every result matches the reference model in order, with throughput of 1 per cycle.
REQ-036 Stall raised for 3 cycles while 4 operations are in flight -> results unchanged, each delayed by exactly 3 cycles, and in_valid during the stall is dropped.
REQ-037 RST_Pad pulsed mid-stream between clock edges -> out_valid=0 at once, no pre-reset result ever emerges, and a fresh operation returns after 5 cycles.
REQ-038 With KSA_PIPE_OVF_EN defined: 8'h7F+8'h01 -> sum=8'h80, ovf=1; 8'h80-8'h01 -> sum=8'h7F, ovf=1; 8'h10+8'h20 -> ovf=0.
